ad_ip_jesd204_tpl_dac_up_arbiter: RTL and testbench

Shares the single up_* register bus of the DAC TPL register map between NUM_REQ requesters, for example the AXI front-end plus an internal DDS/pattern sequencer. Arbitration is round-robin, with one transaction outstanding at a time. A timeout guarantees that every granted request completes. The block sits between the requesters and the up_dac_common/up_dac_channel slave fabric.

---
 rtl/ad_ip_jesd204_tpl_dac_up_arbiter_if.sv | 44 ++++
 rtl/ad_ip_jesd204_tpl_dac_up_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_up_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_up_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_up_arbiter_if: requester and slave sides of the up_* bus
// Revision: 1.0
// ----------------------------------------------------------------------------
interface ad_ip_jesd204_tpl_dac_up_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 14
);
  logic [NUM_REQ-1:0]            req_wreq;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr;
  logic [NUM_REQ*32-1:0]         req_wdata;
  logic [NUM_REQ-1:0]            req_wack;
  logic [NUM_REQ-1:0]            req_rreq;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_raddr;
  logic [31:0]                   req_rdata;
  logic [NUM_REQ-1:0]            req_rack;

  logic                          up_wreq;
  logic [ADDR_WIDTH-1:0]         up_waddr;
  logic [31:0]                   up_wdata;
  logic                          up_wack;
  logic                          up_rreq;
  logic [ADDR_WIDTH-1:0]         up_raddr;
  logic [31:0]                   up_rdata;
  logic                          up_rack;

  // The arbiter: serves the requesters and masters the slave fabric.
  modport master (
    input  req_wreq, req_waddr, req_wdata, req_rreq, req_raddr,
    input  up_wack, up_rdata, up_rack,
    output req_wack, req_rdata, req_rack,
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );

  // Everything around the arbiter: requesters plus slave fabric.
  modport slave (
    output req_wreq, req_waddr, req_wdata, req_rreq, req_raddr,
    output up_wack, up_rdata, up_rack,
    input  req_wack, req_rdata, req_rack,
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr
  );
endinterface
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_up_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_up_arbiter: round-robin sharing of the DAC TPL up_* bus
// Revision: 1.0
// ----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_up_arbiter #(
  parameter int          NUM_REQ        = 2,
  parameter int          ADDR_WIDTH     = 14,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_DEAD
) (
  input  logic                                      up_clk,
  input  logic                                      up_rst,
  ad_ip_jesd204_tpl_dac_up_arbiter_if.master        up_bus,
  output logic [15:0]                               timeout_cnt
);

  localparam int c_PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CW = $clog2(TIMEOUT_CYCLES + 2);
  // Forced completion is pulsed TIMEOUT_CYCLES+2 cycles after the strobe.
  localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q,     state_d;
  logic [c_PW-1:0]       ptr_q,       ptr_d;
  logic [c_PW-1:0]       gnt_q,       gnt_d;
  logic                  op_wr_q,     op_wr_d;
  logic [c_CW-1:0]       cnt_q,       cnt_d;
  logic                  up_wreq_q,   up_wreq_d;
  logic                  up_rreq_q,   up_rreq_d;
  logic [ADDR_WIDTH-1:0] up_waddr_q,  up_waddr_d;
  logic [ADDR_WIDTH-1:0] up_raddr_q,  up_raddr_d;
  logic [31:0]           up_wdata_q,  up_wdata_d;
  logic [NUM_REQ-1:0]    req_wack_q,  req_wack_d;
  logic [NUM_REQ-1:0]    req_rack_q,  req_rack_d;
  logic [31:0]           req_rdata_q, req_rdata_d;
  logic [15:0]           to_cnt_q,    to_cnt_d;

  logic [NUM_REQ-1:0]    req_any;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [c_PW-1:0]       cand;
  logic                  gnt_vld;
  logic [c_PW-1:0]       gnt_idx;
  logic                  slv_ack;

  // Descending scan so the candidate closest to the pointer wins.
  always_comb begin
    req_any = up_bus.req_wreq | up_bus.req_rreq;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = c_PW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_any[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_oh  = NUM_REQ'(1) << gnt_q;
  assign slv_ack = op_wr_q ? up_bus.up_wack : up_bus.up_rack;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    op_wr_d     = op_wr_q;
    cnt_d       = cnt_q;
    up_wreq_d   = 1'b0;
    up_rreq_d   = 1'b0;
    up_waddr_d  = up_waddr_q;
    up_raddr_d  = up_raddr_q;
    up_wdata_d  = up_wdata_q;
    req_wack_d  = '0;
    req_rack_d  = '0;
    req_rdata_d = req_rdata_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          gnt_d   = gnt_idx;
          // A requester holding both requests gets its write first.
          op_wr_d = up_bus.req_wreq[gnt_idx];
          if (up_bus.req_wreq[gnt_idx]) begin
            up_waddr_d = up_bus.req_waddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            up_wdata_d = up_bus.req_wdata[gnt_idx*32 +: 32];
          end else begin
            up_raddr_d = up_bus.req_raddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        up_wreq_d = op_wr_q;
        up_rreq_d = !op_wr_q;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        if (slv_ack) begin
          if (!op_wr_q) begin
            req_rdata_d = up_bus.up_rdata;
          end
          req_wack_d = op_wr_q  ? gnt_oh : '0;
          req_rack_d = !op_wr_q ? gnt_oh : '0;
          state_d    = S_DONE;
        end else if (cnt_q == c_TO_LAST) begin
          if (!op_wr_q) begin
            req_rdata_d = TIMEOUT_RDATA;
          end
          req_wack_d = op_wr_q  ? gnt_oh : '0;
          req_rack_d = !op_wr_q ? gnt_oh : '0;
          to_cnt_d   = (to_cnt_q != 16'hFFFF) ? to_cnt_q + 16'd1 : to_cnt_q;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + c_CW'(1);
        end
      end

      S_DONE: begin
        ptr_d   = (gnt_q == c_PW'(NUM_REQ - 1)) ? '0 : gnt_q + c_PW'(1);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      op_wr_q     <= 1'b0;
      cnt_q       <= '0;
      up_wreq_q   <= 1'b0;
      up_rreq_q   <= 1'b0;
      up_waddr_q  <= '0;
      up_raddr_q  <= '0;
      up_wdata_q  <= '0;
      req_wack_q  <= '0;
      req_rack_q  <= '0;
      req_rdata_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      op_wr_q     <= op_wr_d;
      cnt_q       <= cnt_d;
      up_wreq_q   <= up_wreq_d;
      up_rreq_q   <= up_rreq_d;
      up_waddr_q  <= up_waddr_d;
      up_raddr_q  <= up_raddr_d;
      up_wdata_q  <= up_wdata_d;
      req_wack_q  <= req_wack_d;
      req_rack_q  <= req_rack_d;
      req_rdata_q <= req_rdata_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign up_bus.up_wreq   = up_wreq_q;
  assign up_bus.up_rreq   = up_rreq_q;
  assign up_bus.up_waddr  = up_waddr_q;
  assign up_bus.up_raddr  = up_raddr_q;
  assign up_bus.up_wdata  = up_wdata_q;
  assign up_bus.req_wack  = req_wack_q;
  assign up_bus.req_rack  = req_rack_q;
  assign up_bus.req_rdata = req_rdata_q;
  assign timeout_cnt      = to_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_up_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ad_ip_jesd204_tpl_dac_up_arbiter: directed checks of the up_* arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ad_ip_jesd204_tpl_dac_up_arbiter;

  localparam int c_NREQ = 2;
  localparam int c_AW   = 14;
  localparam int c_TO   = 64;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic [15:0] timeout_cnt;

  int errors = 0;
  int checks = 0;

  ad_ip_jesd204_tpl_dac_up_arbiter_if #(.NUM_REQ(c_NREQ), .ADDR_WIDTH(c_AW)) bus ();

  ad_ip_jesd204_tpl_dac_up_arbiter #(
    .NUM_REQ        (c_NREQ),
    .ADDR_WIDTH     (c_AW),
    .TIMEOUT_CYCLES (c_TO),
    .TIMEOUT_RDATA  (32'hDEAD_DEAD)
  ) dut (
    .up_clk      (up_clk),
    .up_rst      (up_rst),
    .up_bus      (bus),
    .timeout_cnt (timeout_cnt)
  );

  always #5 up_clk = ~up_clk;

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits a bounded number of cycles for a write (rd=0) or read (rd=1) strobe.
  task automatic wait_strobe(input bit rd, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if ((rd ? bus.up_rreq : bus.up_wreq) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int lat;
    bus.req_wreq  = '0;
    bus.req_rreq  = '0;
    bus.req_waddr = '0;
    bus.req_raddr = '0;
    bus.req_wdata = '0;
    bus.up_wack   = 1'b0;
    bus.up_rack   = 1'b0;
    bus.up_rdata  = '0;

    // Reset state
    tick(); tick(); tick();
    up_rst = 1'b0;
    tick();
    check("rst_wreq",    32'(bus.up_wreq),  32'd0);
    check("rst_rreq",    32'(bus.up_rreq),  32'd0);
    check("rst_waddr",   32'(bus.up_waddr), 32'd0);
    check("rst_wdata",   bus.up_wdata,      32'd0);
    check("rst_wack",    32'(bus.req_wack), 32'd0);
    check("rst_rack",    32'(bus.req_rack), 32'd0);
    check("rst_rdata",   bus.req_rdata,     32'd0);
    check("rst_timeout", 32'(timeout_cnt),  32'd0);

    // Single write from requester 0, slave acks 3 cycles after the strobe
    bus.req_wreq           = 2'b01;
    bus.req_waddr[0 +: 14] = 14'h0040;
    bus.req_wdata[0 +: 32] = 32'h1234_5678;
    tick();
    check("w1_no_early_strobe", 32'(bus.up_wreq), 32'd0);
    tick();
    check("w1_strobe", 32'(bus.up_wreq),  32'd1);
    check("w1_addr",   32'(bus.up_waddr), 32'h0040);
    check("w1_data",   bus.up_wdata,      32'h1234_5678);
    check("w1_noread", 32'(bus.up_rreq),  32'd0);
    tick();
    check("w1_pulse_end", 32'(bus.up_wreq), 32'd0);
    tick(); tick();
    bus.up_wack = 1'b1;
    check("w1_no_early_ack", 32'(bus.req_wack), 32'd0);
    tick();
    bus.up_wack = 1'b0;
    check("w1_wack", 32'(bus.req_wack), 32'b01);
    check("w1_rack", 32'(bus.req_rack), 32'b00);
    bus.req_wreq = 2'b00;
    tick();
    check("w1_wack_1cyc", 32'(bus.req_wack), 32'd0);

    // Single read from requester 1
    bus.req_rreq            = 2'b10;
    bus.req_raddr[14 +: 14] = 14'h0102;
    tick(); tick();
    check("r1_strobe", 32'(bus.up_rreq),  32'd1);
    check("r1_addr",   32'(bus.up_raddr), 32'h0102);
    check("r1_nowr",   32'(bus.up_wreq),  32'd0);
    tick();
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'hCAFE_0001;
    tick();
    bus.up_rack  = 1'b0;
    bus.up_rdata = 32'h0;
    check("r1_rack",  32'(bus.req_rack), 32'b10);
    check("r1_rdata", bus.req_rdata,     32'hCAFE_0001);
    check("r1_wack",  32'(bus.req_wack), 32'd0);
    bus.req_rreq = 2'b00;
    tick();

    // Both requesters write continuously: grants alternate starting at 0
    bus.req_waddr[0 +: 14]  = 14'h0010;
    bus.req_waddr[14 +: 14] = 14'h0020;
    bus.req_wdata[0 +: 32]  = 32'h1111_0000;
    bus.req_wdata[32 +: 32] = 32'h2222_0000;
    bus.req_wreq = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_strobe(1'b0, "rr_strobe");
      check("rr_addr",  32'(bus.up_waddr), (i % 2 == 1) ? 32'h0020 : 32'h0010);
      check("rr_data",  bus.up_wdata,      (i % 2 == 1) ? 32'h2222_0000 : 32'h1111_0000);
      tick();
      check("rr_pulse", 32'(bus.up_wreq),  32'd0);
      bus.up_wack = 1'b1;
      tick();
      bus.up_wack = 1'b0;
      check("rr_wack",  32'(bus.req_wack), (i % 2 == 1) ? 32'b10 : 32'b01);
    end
    bus.req_wreq = 2'b00;
    tick(); tick();

    // Read from requester 0 that the slave never acks
    bus.req_rreq           = 2'b01;
    bus.req_raddr[0 +: 14] = 14'h0055;
    wait_strobe(1'b1, "to_strobe");
    check("to_addr", 32'(bus.up_raddr), 32'h0055);
    lat = 0;
    while (bus.req_rack === 2'b00 && lat < 200) begin
      tick();
      lat++;
    end
    check("to_latency", 32'(lat),          32'(c_TO + 2));
    check("to_rack",    32'(bus.req_rack), 32'b01);
    check("to_rdata",   bus.req_rdata,     32'hDEAD_DEAD);
    check("to_count",   32'(timeout_cnt),  32'd1);
    bus.req_rreq = 2'b00;

    // Requester 0 asks for a write and a read at once: write first
    bus.req_waddr[0 +: 14] = 14'h0077;
    bus.req_wdata[0 +: 32] = 32'hA5A5_0077;
    bus.req_raddr[0 +: 14] = 14'h0088;
    bus.req_wreq = 2'b01;
    bus.req_rreq = 2'b01;
    wait_strobe(1'b0, "wr_first_strobe");
    check("wr_first_addr",   32'(bus.up_waddr), 32'h0077);
    check("wr_first_norrd",  32'(bus.up_rreq),  32'd0);
    tick();
    bus.up_wack = 1'b1;
    tick();
    bus.up_wack = 1'b0;
    check("wr_first_wack",   32'(bus.req_wack), 32'b01);
    check("wr_first_norack", 32'(bus.req_rack), 32'b00);
    bus.req_wreq = 2'b00;
    wait_strobe(1'b1, "rd_second_strobe");
    check("rd_second_addr", 32'(bus.up_raddr), 32'h0088);
    check("rd_second_nowr", 32'(bus.up_wreq),  32'd0);
    tick();
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'h5A5A_1234;
    tick();
    bus.up_rack  = 1'b0;
    bus.up_rdata = 32'h0;
    check("rd_second_rack",  32'(bus.req_rack), 32'b01);
    check("rd_second_rdata", bus.req_rdata,     32'h5A5A_1234);
    check("rd_second_tocnt", 32'(timeout_cnt),  32'd1);
    bus.req_rreq = 2'b00;
    tick();

    // Reset while waiting for the slave
    bus.req_waddr[14 +: 14] = 14'h0099;
    bus.req_wdata[32 +: 32] = 32'hBEEF_0099;
    bus.req_wreq = 2'b10;
    wait_strobe(1'b0, "rw_strobe");
    check("rw_addr", 32'(bus.up_waddr), 32'h0099);
    tick();
    up_rst = 1'b1;
    tick();
    check("rw_rst_waddr", 32'(bus.up_waddr), 32'd0);
    check("rw_rst_raddr", 32'(bus.up_raddr), 32'd0);
    check("rw_rst_wdata", bus.up_wdata,      32'd0);
    check("rw_rst_wreq",  32'(bus.up_wreq),  32'd0);
    check("rw_rst_wack",  32'(bus.req_wack), 32'd0);
    check("rw_rst_rdata", bus.req_rdata,     32'd0);
    check("rw_rst_tocnt", 32'(timeout_cnt),  32'd0);
    bus.req_wreq = 2'b00;
    bus.up_wack  = 1'b1;
    tick();
    up_rst = 1'b0;
    tick();
    bus.up_wack = 1'b0;
    check("rw_late_ack0", 32'(bus.req_wack), 32'd0);
    tick();
    check("rw_late_ack1", 32'(bus.req_wack), 32'd0);
    check("rw_idle_wreq", 32'(bus.up_wreq),  32'd0);

    // Pointer restarts at 0 after reset
    bus.req_raddr[0 +: 14]  = 14'h0101;
    bus.req_raddr[14 +: 14] = 14'h0202;
    bus.req_rreq = 2'b11;
    wait_strobe(1'b1, "rp_strobe");
    check("rp_addr", 32'(bus.up_raddr), 32'h0101);
    tick();
    bus.up_rack  = 1'b1;
    bus.up_rdata = 32'h0000_0101;
    tick();
    bus.up_rack  = 1'b0;
    check("rp_rack",  32'(bus.req_rack), 32'b01);
    check("rp_rdata", bus.req_rdata,     32'h0000_0101);
    bus.req_rreq = 2'b00;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
